ni_packetizer: RTL and testbench



---
 rtl/ni_packetizer_if.sv | 47 ++++
 rtl/ni_packetizer.sv | 201 ++++++++++++++++++++
 tb/tb_ni_packetizer.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ni_packetizer_if.sv
// Bundle of the core request, payload and switch-controller flit channels
// seen by the NI packetizer. The core/switch side uses the master modport,
// the packetizer uses the slave modport.
`timescale 1ns/1ps

interface ni_packetizer_if #(
    parameter int FLIT_W = 8,
    parameter int LEN_W  = 3
);
    // Packet request from the local core
    logic              core_req;
    logic [1:0]        core_dest;
    logic [LEN_W-1:0]  core_len;
    logic              core_ack;

    // Payload byte stream from the local core
    logic [FLIT_W-1:0] pl_data;
    logic              pl_valid;
    logic              pl_ready;

    // Flit channel towards the switch controller
    logic              noc_ready;
    logic              flit_valid;
    logic [FLIT_W-1:0] flit_out_NI;

    // Status pulses and level
    logic              busy;
    logic              pkt_done;
    logic              len_err;
    logic              rsv_err;

    modport master (
        output core_req, core_dest, core_len,
        output pl_data, pl_valid,
        output noc_ready,
        input  core_ack, pl_ready, flit_valid, flit_out_NI,
        input  busy, pkt_done, len_err, rsv_err
    );

    modport slave (
        input  core_req, core_dest, core_len,
        input  pl_data, pl_valid,
        input  noc_ready,
        output core_ack, pl_ready, flit_valid, flit_out_NI,
        output busy, pkt_done, len_err, rsv_err
    );
endinterface

// File: rtl/ni_packetizer.sv
// NI transmit packetizer: turns a core request plus payload bytes into a
// head flit, body flits and a trailer flit for the router switch controller,
// honouring noc_ready backpressure and blanking the bus when idle.
`timescale 1ns/1ps

module ni_packetizer #(
    parameter int                FLIT_W   = 8,
    parameter int                LEN_W    = 3,
    parameter int                MAX_LEN  = 4,
    parameter logic [5:0]        HEAD_TAG = 6'b101111,
    parameter logic [FLIT_W-1:0] TRAILER  = 8'hFF,
    parameter logic [FLIT_W-1:0] RSV_SUB  = 8'h7F
) (
    input  logic              clk,
    input  logic              rst,
    ni_packetizer_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HEAD  = 2'd1,
        BODY  = 2'd2,
        TRAIL = 2'd3
    } state_e;

    state_e            state_q, state_d;

    // The destination is captured straight into the head flit held in the
    // output register, so only the remaining payload count needs its own flop.
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic [FLIT_W-1:0] flit_q, flit_d;
    logic              flit_valid_q, flit_valid_d;
    logic              core_ack_q, core_ack_d;
    logic              pkt_done_q, pkt_done_d;
    logic              len_err_q, len_err_d;
    logic              rsv_err_q, rsv_err_d;
    logic              busy_q, busy_d;

    logic              xfer;
    logic              len_ok;
    logic              req_take;
    logic              pl_ready_w;
    logic              accept;
    logic              pl_rsv;
    logic [FLIT_W-1:0] pl_byte;
    logic              load_trailer;

    // A flit leaves the output register on this edge
    assign xfer = flit_valid_q && bus.noc_ready;

    assign len_ok = (bus.core_len != '0) && (bus.core_len <= LEN_W'(MAX_LEN));

    // A held core_req must not be consumed twice: the core only sees the
    // registered ack one cycle late, so skip the cycle in which ack is high.
    assign req_take = (state_q == IDLE) && bus.core_req && !core_ack_q;

    // Payload may enter whenever the output register is free or draining,
    // including the head cycle so body flits follow the head back-to-back.
    assign pl_ready_w = ((state_q == HEAD) || (state_q == BODY)) &&
                        (rem_q != '0) && (!flit_valid_q || bus.noc_ready);
    assign accept     = pl_ready_w && bus.pl_valid;

    // Bytes that would alias the idle, trailer or head encodings are replaced
    assign pl_rsv  = (bus.pl_data == '0) || (bus.pl_data == '1) ||
                     (bus.pl_data[FLIT_W-1 -: 6] == HEAD_TAG);
    assign pl_byte = pl_rsv ? RSV_SUB : bus.pl_data;

    // Trailer goes out once the payload count is exhausted and the register frees up
    assign load_trailer = (state_q == BODY) && (rem_q == '0) &&
                          (!flit_valid_q || bus.noc_ready);

    // State and output registers with synchronous reset to an empty, idle NI
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            rem_q        <= '0;
            flit_q       <= '0;
            flit_valid_q <= 1'b0;
            core_ack_q   <= 1'b0;
            pkt_done_q   <= 1'b0;
            len_err_q    <= 1'b0;
            rsv_err_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            rem_q        <= rem_d;
            flit_q       <= flit_d;
            flit_valid_q <= flit_valid_d;
            core_ack_q   <= core_ack_d;
            pkt_done_q   <= pkt_done_d;
            len_err_q    <= len_err_d;
            rsv_err_q    <= rsv_err_d;
            busy_q       <= busy_d;
        end
    end

    // Next-state sequencing through head, body and trailer phases
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req_take && len_ok) begin
                    state_d = HEAD;
                end
            end
            HEAD: begin
                if (xfer) begin
                    state_d = BODY;
                end
            end
            BODY: begin
                if (load_trailer) begin
                    state_d = TRAIL;
                end
            end
            TRAIL: begin
                if (xfer) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output register, payload counter and status pulse updates per state
    always_comb begin
        rem_d        = rem_q;
        flit_d       = flit_q;
        flit_valid_d = flit_valid_q;
        core_ack_d   = 1'b0;
        pkt_done_d   = 1'b0;
        len_err_d    = 1'b0;
        rsv_err_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_take) begin
                    core_ack_d = 1'b1;
                    if (len_ok) begin
                        rem_d        = bus.core_len;
                        flit_d       = FLIT_W'({HEAD_TAG, bus.core_dest});
                        flit_valid_d = 1'b1;
                    end else begin
                        len_err_d = 1'b1;
                    end
                end
            end
            HEAD, BODY: begin
                if (accept) begin
                    flit_d       = pl_byte;
                    flit_valid_d = 1'b1;
                    rem_d        = rem_q - LEN_W'(1);
                    rsv_err_d    = pl_rsv;
                end else if (load_trailer) begin
                    flit_d       = TRAILER;
                    flit_valid_d = 1'b1;
                end else if (xfer) begin
                    flit_d       = '0;
                    flit_valid_d = 1'b0;
                end
            end
            TRAIL: begin
                if (xfer) begin
                    flit_d       = '0;
                    flit_valid_d = 1'b0;
                    pkt_done_d   = 1'b1;
                end
            end
            default: begin
                flit_d       = '0;
                flit_valid_d = 1'b0;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    assign bus.core_ack    = core_ack_q;
    assign bus.pl_ready    = pl_ready_w;
    assign bus.flit_valid  = flit_valid_q;
    assign bus.flit_out_NI = flit_q;
    assign bus.busy        = busy_q;
    assign bus.pkt_done    = pkt_done_q;
    assign bus.len_err     = len_err_q;
    assign bus.rsv_err     = rsv_err_q;

    // A stalled flit must stay put until the controller takes it
    a_hold_under_stall: assert property (@(posedge clk) disable iff (rst)
        (flit_valid_q && !bus.noc_ready) |=> (flit_valid_q && $stable(flit_q)));

    // The bus is blanked whenever no flit is offered
    a_blank_when_idle: assert property (@(posedge clk) disable iff (rst)
        !flit_valid_q |-> (flit_q == '0));

    // busy mirrors the state register
    a_busy_matches_state: assert property (@(posedge clk) disable iff (rst)
        busy_q == (state_q != IDLE));

    // A rejection is always reported together with the ack
    a_len_err_with_ack: assert property (@(posedge clk) disable iff (rst)
        len_err_q |-> core_ack_q);

endmodule

// File: tb/tb_ni_packetizer.sv
// Self-checking bench for ni_packetizer: a scoreboard queue receives the
// expected flits as requests and payload bytes are driven, and is drained
// as flits transfer to the modelled switch controller.
`timescale 1ns/1ps

module tb_ni_packetizer;

    localparam int FLIT_W = 8;
    localparam int LEN_W  = 3;
    localparam logic [5:0] TAG = 6'b101111;

    logic clk = 1'b0;
    logic rst;

    int check_count = 0;
    int fail_count  = 0;

    logic [7:0] sb_q[$];
    logic       stall_prev = 1'b0;
    logic [7:0] prev_flit  = 8'h00;

    ni_packetizer_if #(.FLIT_W(FLIT_W), .LEN_W(LEN_W)) bus();

    ni_packetizer #(.FLIT_W(FLIT_W), .LEN_W(LEN_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running 10 ns clock
    always #5 clk = ~clk;

    // Hard stop in case any sequence wedges
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    function automatic logic is_rsv(input logic [7:0] b);
        return (b == 8'h00) || (b == 8'hFF) || (b[7:2] == TAG);
    endfunction

    function automatic logic [7:0] exp_byte(input logic [7:0] b);
        return is_rsv(b) ? 8'h7F : b;
    endfunction

    // Switch-controller side: pop on each transfer, check hold and blanking
    task automatic sample_neg();
        logic [7:0] exp;
        @(negedge clk);
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                checkOutput("hold_valid", bus.flit_valid, 1);
                checkOutput("hold_data", bus.flit_out_NI, prev_flit);
            end
            if (bus.flit_valid && bus.noc_ready) begin
                if (sb_q.size() == 0) begin
                    checkOutput("sb_underflow", sb_q.size(), 1);
                end else begin
                    exp = sb_q.pop_front();
                    checkOutput("flit", bus.flit_out_NI, exp);
                end
            end else if (!bus.flit_valid) begin
                checkOutput("blank_bus", bus.flit_out_NI, 0);
            end
            stall_prev = bus.flit_valid && !bus.noc_ready;
            prev_flit  = bus.flit_out_NI;
        end
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    // Drive one request and its payload; bytes[8*i +: 8] is payload byte i
    task automatic applyStimulus(input logic [1:0] dest, input logic [2:0] len,
                                 input logic [31:0] bytes, input int gap,
                                 input int stall_lo, input int stall_hi,
                                 input int exp_rsv, input int exp_held,
                                 input int exp_bubbles, input int exp_done);
        logic       len_ok;
        logic [7:0] head;
        logic       done;
        int         cyc, idx, gapc, rsv_cnt, held, bubbles, done_cyc;

        len_ok = (len >= 3'd1) && (len <= 3'd4);
        head   = {TAG, dest};
        bus.core_req  = 1'b1;
        bus.core_dest = dest;
        bus.core_len  = len;
        bus.noc_ready = 1'b1;
        bus.pl_valid  = 1'b0;
        if (len_ok) sb_q.push_back(head);
        sample_neg();
        advance();
        checkOutput("core_ack", bus.core_ack, 1);
        checkOutput("len_err", bus.len_err, {31'd0, !len_ok});
        checkOutput("busy_after_req", bus.busy, {31'd0, len_ok});
        bus.core_req = 1'b0;

        if (!len_ok) begin
            checkOutput("rej_flit_valid", bus.flit_valid, 0);
            sample_neg();
            advance();
            checkOutput("rej_ack_pulse", bus.core_ack, 0);
            checkOutput("rej_busy", bus.busy, 0);
            checkOutput("rej_no_flit", bus.flit_valid, 0);
            return;
        end

        checkOutput("head_flit", bus.flit_out_NI, head);
        checkOutput("head_valid", bus.flit_valid, 1);

        cyc = 1; idx = 0; gapc = 0; rsv_cnt = 0; held = 0; bubbles = 0;
        done = 1'b0; done_cyc = -1;
        for (int k = 0; k < 40 && !done; k++) begin
            bus.noc_ready = !((cyc >= stall_lo) && (cyc <= stall_hi));
            if (idx < int'(len) && gapc == 0) begin
                bus.pl_valid = 1'b1;
                bus.pl_data  = bytes[8*idx +: 8];
            end else begin
                bus.pl_valid = 1'b0;
            end
            sample_neg();
            if (bus.rsv_err) rsv_cnt++;
            if (bus.flit_valid && !bus.noc_ready) held++;
            if (bus.busy && !bus.flit_valid) bubbles++;
            if (!bus.noc_ready) checkOutput("pl_ready_stall", bus.pl_ready, 0);
            if (bus.pkt_done) begin
                done     = 1'b1;
                done_cyc = cyc;
                checkOutput("busy_after_done", bus.busy, 0);
            end
            if (bus.pl_valid && bus.pl_ready) begin
                sb_q.push_back(exp_byte(bus.pl_data));
                idx++;
                gapc = gap;
                if (idx == int'(len)) sb_q.push_back(8'hFF);
            end else if (!bus.pl_valid && gapc > 0) begin
                gapc--;
            end
            advance();
            cyc++;
        end
        bus.pl_valid  = 1'b0;
        bus.noc_ready = 1'b1;

        checkOutput("pkt_done_seen", {31'd0, done}, 1);
        checkOutput("done_cycle", done_cyc, exp_done);
        checkOutput("rsv_err_count", rsv_cnt, exp_rsv);
        checkOutput("stall_cycles", held, exp_held);
        checkOutput("bubble_cycles", bubbles, exp_bubbles);
        checkOutput("sb_drained", sb_q.size(), 0);

        sample_neg();
        checkOutput("done_pulse", bus.pkt_done, 0);
        advance();
    endtask

    // Abandon a packet mid-body with two payload flits still owed
    task automatic reset_mid_packet();
        bus.core_req  = 1'b1;
        bus.core_dest = 2'd2;
        bus.core_len  = 3'd4;
        bus.noc_ready = 1'b1;
        bus.pl_valid  = 1'b0;
        sb_q.push_back({TAG, 2'd2});
        sample_neg();
        advance();
        checkOutput("rst_test_ack", bus.core_ack, 1);
        bus.core_req = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.pl_valid = 1'b1;
            bus.pl_data  = 8'h21 + 8'(i);
            sample_neg();
            checkOutput("rst_test_accept", bus.pl_ready, 1);
            if (bus.pl_valid && bus.pl_ready) sb_q.push_back(exp_byte(bus.pl_data));
            advance();
        end
        checkOutput("rst_test_busy", bus.busy, 1);
        rst          = 1'b1;
        bus.pl_valid = 1'b0;
        sample_neg();
        advance();
        checkOutput("midrst_flit", bus.flit_out_NI, 0);
        checkOutput("midrst_flags",
                    {bus.flit_valid, bus.pl_ready, bus.core_ack, bus.busy,
                     bus.pkt_done, bus.len_err, bus.rsv_err}, 0);
        rst = 1'b0;
        sb_q.delete();
        sample_neg();
        checkOutput("midrst_no_trailer", bus.flit_valid, 0);
        advance();
    endtask

    // Top-level test sequence
    initial begin
        rst           = 1'b1;
        bus.core_req  = 1'b0;
        bus.core_dest = 2'd0;
        bus.core_len  = 3'd0;
        bus.pl_data   = 8'h00;
        bus.pl_valid  = 1'b0;
        bus.noc_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_flit", bus.flit_out_NI, 0);
        checkOutput("reset_flags",
                    {bus.flit_valid, bus.pl_ready, bus.core_ack, bus.busy,
                     bus.pkt_done, bus.len_err, bus.rsv_err}, 0);
        rst = 1'b0;
        advance();

        $display("[TB] basic packet dest=2 len=3");
        applyStimulus(2'd2, 3'd3, 32'h00332211, 0, 100, 99, 0, 0, 0, 6);

        $display("[TB] same packet with noc_ready low in cycles 2-4");
        applyStimulus(2'd2, 3'd3, 32'h00332211, 0, 2, 4, 0, 3, 0, 9);

        $display("[TB] payload gap between body bytes");
        applyStimulus(2'd0, 3'd2, 32'h00000605, 1, 100, 99, 0, 0, 1, 6);

        $display("[TB] illegal lengths");
        applyStimulus(2'd1, 3'd0, 32'h0, 0, 100, 99, 0, 0, 0, 0);
        applyStimulus(2'd1, 3'd5, 32'h0, 0, 100, 99, 0, 0, 0, 0);
        applyStimulus(2'd3, 3'd7, 32'h0, 0, 100, 99, 0, 0, 0, 0);

        $display("[TB] reserved payload bytes");
        applyStimulus(2'd3, 3'd3, 32'h00BD00FF, 0, 100, 99, 3, 0, 0, 6);

        $display("[TB] maximum length with reserved boundary bytes");
        applyStimulus(2'd1, 3'd4, 32'hC0017EBC, 0, 100, 99, 1, 0, 0, 7);

        $display("[TB] reset in the middle of a body");
        reset_mid_packet();
        applyStimulus(2'd1, 3'd1, 32'h00000042, 0, 100, 99, 0, 0, 0, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", check_count, fail_count);
        $finish;
    end

endmodule
